// File: rtl/ckpt_pkg.sv
// Shared definitions for the checkpoint monitor: checkpoint codes, status encoding and the
// logged event record.
package ckpt_pkg;

  localparam int unsigned CODE_W   = 16;
  localparam int unsigned STAGE_W  = 8;
  localparam int unsigned DEF_TS_W = 32;

  localparam logic [CODE_W-1:0] START_CODE = 16'hAB40;
  localparam logic [CODE_W-1:0] PASS_CODE  = 16'hAB51;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StRun     = 2'b01,
    StPass    = 2'b10,
    StTimeout = 2'b11
  } status_e;

  // Event record with the default timestamp width; the FIFO stores it as a flat word.
  typedef struct packed {
    logic [CODE_W-1:0]   code;
    logic [STAGE_W-1:0]  stage;
    logic [DEF_TS_W-1:0] ts;
  } ckpt_evt_t;

  function automatic logic is_terminal(status_e s);
    return (s == StPass) || (s == StTimeout);
  endfunction

endpackage

// File: rtl/ckpt_event_fifo.sv
// Synchronous event FIFO with registered head; a push into an empty FIFO becomes visible on
// the following cycle. Head data reads as zero while empty.
module ckpt_event_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 56
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] LevelFull = (PtrW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q;
  logic [PtrW-1:0]  rptr_q;
  logic [PtrW:0]    level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LevelFull);
  assign empty_o = (level_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign data_o  = empty_o ? '0 : mem_q[rptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/ckpt_monitor.sv
// Checkpoint monitor: logs every change of the firmware checkpoint word into an event FIFO and
// tracks test progress. Define CKPT_DEBOUNCE_EN to require a stable window before acceptance.
module ckpt_monitor
  import ckpt_pkg::*;
#(
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned TS_W            = 32,
  parameter int unsigned TIMEOUT_CYCLES  = 250000,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                   clock,
  input  logic                   resetb,
  input  logic [15:0]            checkbits,
  input  logic [7:0]             stagebits,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [15:0]            evt_code,
  output logic [7:0]             evt_stage,
  output logic [TS_W-1:0]        evt_time,
  output logic [$clog2(DEPTH):0] evt_level,
  output logic                   overflow,
  output logic                   stage_err,
  output logic [1:0]             status,
  output logic                   done
);

  localparam int unsigned RecW = CODE_W + STAGE_W + TS_W;
  localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  logic [15:0]     prev_code_q;
  logic [TS_W-1:0] ts_q;
  logic            overflow_q;
  logic            accept;
  logic [15:0]     acc_code;
  logic [7:0]      acc_stage;

`ifdef CKPT_DEBOUNCE_EN
  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DbW-1:0] DbFull = DbW'(DEBOUNCE_CYCLES);

  logic [15:0]    cand_q;
  logic [DbW-1:0] db_cnt_q;

  // Any change restarts the window on the new candidate value.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      cand_q   <= '0;
      db_cnt_q <= '0;
    end else if (checkbits != cand_q) begin
      cand_q   <= checkbits;
      db_cnt_q <= DbW'(1);
    end else if (db_cnt_q != DbFull) begin
      db_cnt_q <= db_cnt_q + 1'b1;
    end
  end

  assign accept   = (db_cnt_q == DbFull) && (cand_q != prev_code_q);
  assign acc_code = cand_q;
`else
  assign accept   = (checkbits != prev_code_q);
  assign acc_code = checkbits;
`endif
  assign acc_stage = stagebits;

  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [RecW-1:0] head;

  assign pop = evt_valid & evt_ready;

  always_ff @(posedge clock) begin
    if (!resetb) begin
      prev_code_q <= '0;
      ts_q        <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (ts_q != '1) begin
        ts_q <= ts_q + 1'b1;
      end
      if (accept) begin
        prev_code_q <= acc_code;
      end
      if (accept && fifo_full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  ckpt_event_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(RecW)
  ) u_fifo (
    .clk_i  (clock),
    .rst_ni (resetb),
    .push_i (accept),
    .data_i ({acc_code, acc_stage, ts_q}),
    .pop_i  (pop),
    .data_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .level_o(evt_level)
  );

  assign evt_valid                       = ~fifo_empty;
  assign {evt_code, evt_stage, evt_time} = head;
  assign overflow                        = overflow_q;

  // Accepted events (including dropped ones) are registered once, so the FSM reacts one cycle
  // after the event edge.
  logic            fsm_evt_q;
  logic [15:0]     fsm_code_q;
  logic [7:0]      fsm_stage_q;
  status_e         status_q;
  logic [7:0]      last_stage_q;
  logic [WdW-1:0]  wdog_q;
  logic            stage_err_q;

  always_ff @(posedge clock) begin
    if (!resetb) begin
      fsm_evt_q    <= 1'b0;
      fsm_code_q   <= '0;
      fsm_stage_q  <= '0;
      status_q     <= StIdle;
      last_stage_q <= '0;
      wdog_q       <= '0;
      stage_err_q  <= 1'b0;
    end else begin
      fsm_evt_q   <= accept;
      fsm_code_q  <= acc_code;
      fsm_stage_q <= acc_stage;
      case (status_q)
        StIdle: begin
          if (fsm_evt_q && (fsm_code_q == START_CODE)) begin
            status_q     <= StRun;
            last_stage_q <= fsm_stage_q;
            wdog_q       <= '0;
            if (fsm_stage_q != '0) begin
              stage_err_q <= 1'b1;
            end
          end else if (fsm_evt_q && (fsm_code_q == PASS_CODE)) begin
            status_q    <= StPass;
            stage_err_q <= 1'b1;
          end
        end
        StRun: begin
          // An event in the cycle the watchdog would expire takes precedence.
          if (fsm_evt_q) begin
            wdog_q <= '0;
            if (fsm_code_q == START_CODE) begin
              if (fsm_stage_q < last_stage_q) begin
                stage_err_q <= 1'b1;
              end
              last_stage_q <= fsm_stage_q;
            end else if (fsm_code_q == PASS_CODE) begin
              status_q <= StPass;
            end
          end else begin
            wdog_q <= wdog_q + 1'b1;
            if (wdog_q == WdLast) begin
              status_q <= StTimeout;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign status    = status_q;
  assign done      = is_terminal(status_q);
  assign stage_err = stage_err_q;

endmodule

// File: tb/tb_ckpt_monitor.sv
// Self-checking bench for ckpt_monitor: table-driven FSM vectors, a scoreboard of expected
// events, and hand sequences for FIFO fill/overflow, watchdog timing and debounce.
module tb_ckpt_monitor;
  import ckpt_pkg::*;

  localparam int unsigned DEPTH    = 8;
  localparam int unsigned TS_W     = 32;
  localparam int unsigned TIMEOUT  = 300;
  localparam int unsigned DEBOUNCE = 4;

  logic            clock = 1'b0;
  logic            resetb = 1'b0;
  logic [15:0]     checkbits = '0;
  logic [7:0]      stagebits = '0;
  logic            evt_valid;
  logic            evt_ready = 1'b1;
  logic [15:0]     evt_code;
  logic [7:0]      evt_stage;
  logic [TS_W-1:0] evt_time;
  logic [3:0]      evt_level;
  logic            overflow;
  logic            stage_err;
  logic [1:0]      status;
  logic            done;

  always #5 clock = ~clock;

  ckpt_monitor #(
    .DEPTH          (DEPTH),
    .TS_W           (TS_W),
    .TIMEOUT_CYCLES (TIMEOUT),
    .DEBOUNCE_CYCLES(DEBOUNCE)
  ) dut (
    .clock    (clock),
    .resetb   (resetb),
    .checkbits(checkbits),
    .stagebits(stagebits),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_code (evt_code),
    .evt_stage(evt_stage),
    .evt_time (evt_time),
    .evt_level(evt_level),
    .overflow (overflow),
    .stage_err(stage_err),
    .status   (status),
    .done     (done)
  );

  int          n_checks = 0;
  int          n_err = 0;
  ckpt_evt_t   exp_q[$];
  logic [15:0] prev_m = '0;
  logic [31:0] ts_m = '0;
  int          lvl_m = 0;
  bit          model_on = 1'b1;

  typedef struct {
    bit          rst;
    logic [15:0] code;
    logic [7:0]  stage;
    status_e     exp_status;
    logic        exp_err;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Compare/pop the head if it leaves at this edge, predict pushes, then advance one clock.
  task automatic tick();
    bit        pop;
    ckpt_evt_t got;
    pop = evt_valid && evt_ready;
    if (pop) begin
      got = ckpt_evt_t'({evt_code, evt_stage, evt_time});
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL evt_unexpected: got 0x%0h, required no event", got);
      end else begin
        check("evt_head", 64'(got), 64'(exp_q.pop_front()));
      end
    end
    if (model_on && resetb && (checkbits != prev_m)) begin
      if (lvl_m == int'(DEPTH) && !pop) begin
        // dropped: nothing to expect
      end else begin
        exp_q.push_back(ckpt_evt_t'({checkbits, stagebits, ts_m}));
        lvl_m++;
      end
      prev_m = checkbits;
    end
    if (pop) lvl_m--;
    @(posedge clock);
    #1;
    if (resetb && ts_m != '1) ts_m++;
  endtask

  task automatic do_reset();
    resetb    = 1'b0;
    checkbits = '0;
    stagebits = '0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    resetb = 1'b1;
    exp_q.delete();
    prev_m = '0;
    ts_m   = '0;
    lvl_m  = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_status"}, 64'(status), 64'(StIdle));
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_valid"}, 64'(evt_valid), 64'd0);
    check({tag, "_level"}, 64'(evt_level), 64'd0);
    check({tag, "_ovf"}, 64'(overflow), 64'd0);
    check({tag, "_err"}, 64'(stage_err), 64'd0);
    check({tag, "_head"}, 64'({evt_code, evt_stage, evt_time}), 64'd0);
  endtask

  task automatic add_vec(input bit rst, input logic [15:0] code, input logic [7:0] stage,
                         input status_e st, input logic err);
    vec_t v;
    v.rst        = rst;
    v.code       = code;
    v.stage      = stage;
    v.exp_status = st;
    v.exp_err    = err;
    vecs.push_back(v);
  endtask

  initial begin
    evt_ready = 1'b1;
    do_reset();
    check_reset_state("reset");

`ifdef CKPT_DEBOUNCE_EN
    model_on = 1'b0;
    tick();
    tick();
    // Two-cycle glitch must not produce an event.
    checkbits = 16'h1234;
    tick();
    tick();
    checkbits = 16'h0000;
    for (int i = 0; i < 6; i++) tick();
    check("db_glitch_valid", 64'(evt_valid), 64'd0);
    check("db_glitch_level", 64'(evt_level), 64'd0);
    checkbits = 16'h5678;
    stagebits = 8'd7;
    for (int i = 0; i < 4; i++) tick();
    check("db_not_yet", 64'(evt_valid), 64'd0);
    stagebits = 8'd9;
    exp_q.push_back(ckpt_evt_t'({16'h5678, 8'd9, ts_m}));
    tick();
    check("db_latency_valid", 64'(evt_valid), 64'd1);
    tick();
    check("db_drained", 64'(exp_q.size()), 64'd0);
    check("db_level_end", 64'(evt_level), 64'd0);
`else
    // First event latency: head one cycle after the edge, status two cycles after the change.
    tick();
    tick();
    tick();
    checkbits = START_CODE;
    stagebits = 8'd0;
    check("valid_before_edge", 64'(evt_valid), 64'd0);
    tick();
    check("valid_after_push", 64'(evt_valid), 64'd1);
    check("level_after_push", 64'(evt_level), 64'd1);
    check("status_one_cycle", 64'(status), 64'(StIdle));
    tick();
    check("status_two_cycles", 64'(status), 64'(StRun));

    add_vec(1, 16'h0000, 8'd0, StIdle, 1'b0);
    add_vec(0, 16'hAB40, 8'd0, StRun, 1'b0);
    add_vec(0, 16'h0101, 8'd0, StRun, 1'b0);
    add_vec(0, 16'hAB40, 8'd1, StRun, 1'b0);
    add_vec(0, 16'h0102, 8'd1, StRun, 1'b0);
    add_vec(0, 16'h0102, 8'd7, StRun, 1'b0);
    add_vec(0, 16'hAB40, 8'd2, StRun, 1'b0);
    add_vec(0, 16'h0103, 8'd2, StRun, 1'b0);
    add_vec(0, 16'hAB40, 8'd9, StRun, 1'b0);
    add_vec(0, 16'hAB51, 8'd9, StPass, 1'b0);
    add_vec(0, 16'h0104, 8'd9, StPass, 1'b0);
    add_vec(1, 16'h0000, 8'd0, StIdle, 1'b0);
    add_vec(0, 16'hAB40, 8'd0, StRun, 1'b0);
    add_vec(0, 16'h0201, 8'd0, StRun, 1'b0);
    add_vec(0, 16'hAB40, 8'd3, StRun, 1'b0);
    add_vec(0, 16'h0202, 8'd3, StRun, 1'b0);
    add_vec(0, 16'hAB40, 8'd3, StRun, 1'b0);
    add_vec(0, 16'h0203, 8'd3, StRun, 1'b0);
    add_vec(0, 16'hAB40, 8'd1, StRun, 1'b1);
    add_vec(0, 16'h0204, 8'd1, StRun, 1'b1);
    add_vec(0, 16'hAB51, 8'd1, StPass, 1'b1);
    add_vec(1, 16'h0000, 8'd0, StIdle, 1'b0);
    add_vec(0, 16'hAB51, 8'd0, StPass, 1'b1);
    add_vec(1, 16'h0000, 8'd0, StIdle, 1'b0);
    add_vec(0, 16'h1234, 8'd0, StIdle, 1'b0);
    add_vec(0, 16'hAB40, 8'd5, StRun, 1'b1);
    add_vec(0, 16'h0301, 8'd5, StRun, 1'b1);
    add_vec(0, 16'hAB40, 8'd5, StRun, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) begin
        do_reset();
        check_reset_state($sformatf("vec%0d_rst", i));
      end else begin
        checkbits = vecs[i].code;
        stagebits = vecs[i].stage;
        tick();
        tick();
        check($sformatf("vec%0d_status", i), 64'(status), 64'(vecs[i].exp_status));
        check($sformatf("vec%0d_err", i), 64'(stage_err), 64'(vecs[i].exp_err));
        check($sformatf("vec%0d_done", i), 64'(done),
              64'(vecs[i].exp_status == StPass || vecs[i].exp_status == StTimeout));
        check($sformatf("vec%0d_level", i), 64'(evt_level), 64'd0);
      end
    end

    // PASS is terminal and the watchdog is frozen there.
    do_reset();
    checkbits = START_CODE;
    tick();
    tick();
    checkbits = PASS_CODE;
    tick();
    tick();
    for (int i = 0; i < int'(TIMEOUT) + 10; i++) tick();
    check("pass_frozen", 64'(status), 64'(StPass));
    checkbits = 16'h0505;
    tick();
    tick();
    check("pass_terminal", 64'(status), 64'(StPass));

    // FIFO fill, pop+push while full, then overflow.
    do_reset();
    evt_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkbits = 16'h1000 + 16'(i);
      stagebits = 8'(i);
      tick();
    end
    check("fill_level", 64'(evt_level), 64'd8);
    check("fill_ovf", 64'(overflow), 64'd0);
    evt_ready = 1'b1;
    checkbits = 16'h2000;
    tick();
    evt_ready = 1'b0;
    check("full_pp_level", 64'(evt_level), 64'd8);
    check("full_pp_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 2; i++) begin
      checkbits = 16'h3000 + 16'(i);
      tick();
    end
    check("ovf_level", 64'(evt_level), 64'd8);
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_status_idle", 64'(status), 64'(StIdle));
    tick();
    tick();
    check("hold_head_code", 64'(evt_code), 64'h1001);
    check("hold_head_stage", 64'(evt_stage), 64'd1);
    evt_ready = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    check("drain_level", 64'(evt_level), 64'd0);
    check("drain_valid", 64'(evt_valid), 64'd0);
    check("drain_sb", 64'(exp_q.size()), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Reset mid-operation discards queued events.
    evt_ready = 1'b0;
    checkbits = 16'h4000;
    tick();
    checkbits = 16'h4001;
    tick();
    check("mid_level", 64'(evt_level), 64'd2);
    do_reset();
    evt_ready = 1'b1;
    check_reset_state("mid_rst");

    // Watchdog expiry exactly TIMEOUT cycles after entering RUN.
    checkbits = START_CODE;
    tick();
    tick();
    check("to_run", 64'(status), 64'(StRun));
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) tick();
    check("to_before", 64'(status), 64'(StRun));
    tick();
    check("to_fire", 64'(status), 64'(StTimeout));
    check("to_done", 64'(done), 64'd1);

    // An event reaching the FSM in the expiry cycle keeps RUN and re-arms the watchdog.
    do_reset();
    checkbits = START_CODE;
    tick();
    tick();
    for (int i = 0; i < int'(TIMEOUT) - 2; i++) tick();
    checkbits = 16'h3333;
    tick();
    tick();
    check("to_evt_wins", 64'(status), 64'(StRun));
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) tick();
    check("to_rearm_before", 64'(status), 64'(StRun));
    tick();
    check("to_rearm_fire", 64'(status), 64'(StTimeout));
    tick();
    check("end_sb", 64'(exp_q.size()), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ckpt_monitor.md
Name: ckpt_monitor

Overview:
- Synthesizable consumer of the firmware checkpoint word driven on the user-project GPIOs: checkbits = mprj_io[31:16], stagebits = mprj_io[7:0].
- Detects every change of checkbits and logs {code, stage, timestamp} into an event FIFO.
- Tracks test progress through a small FSM: start code, ordered stages, pass code, watchdog timeout.
- Sits directly downstream of the FIR-control firmware's GPIO reporting, alongside the caravel top in lab benches and emulation.

Parameters:
- DEPTH, 8, event FIFO entries (power of two, ≥2).
- TS_W, 32, timestamp width in cycles.
- TIMEOUT_CYCLES, 250000, cycles in RUN with no accepted event before TIMEOUT.
- DEBOUNCE_CYCLES, 4, stability window; used only with CKPT_DEBOUNCE_EN.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- resetb  in  1  synchronous, active-low reset.
- checkbits  in  16  checkpoint code (mprj_io[31:16]).
- stagebits  in  8  stage number (mprj_io[7:0]).
- evt_valid  out  1  FIFO head valid.
- evt_ready  in  1  consumer pops head when evt_valid & evt_ready.
- evt_code  out  16  head code.
- evt_stage  out  8  head stage.
- evt_time  out  TS_W  head timestamp.
- evt_level  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: event dropped because the FIFO was full.
- stage_err  out  1  sticky: stage order or sequence violation.
- status  out  2  00 IDLE, 01 RUN, 10 PASS, 11 TIMEOUT.
- done  out  1  status is PASS or TIMEOUT.

Behaviour:
- Reset (resetb=0 at a clock edge) clears all state:
  - prev_code = 0, timestamp = 0, watchdog = 0, last_stage = 0.
  - FIFO emptied.
  - evt_valid = 0, evt_code/evt_stage/evt_time = 0, evt_level = 0.
  - overflow = 0, stage_err = 0, status = IDLE, done = 0.
- Reset mid-operation discards queued events.
- Timestamp: free-running, increments every cycle out of reset, saturates at all-ones.
- Change detect:
  - change = (checkbits != prev_code).
  - On change, at the next edge: prev_code <= checkbits and one event {checkbits, stagebits, timestamp} is accepted.
  - A stagebits change without a checkbits change is not an event.
- FIFO:
  - A push into an empty FIFO gives evt_valid=1 in the following cycle; there is no combinational bypass.
  - Push when full with no pop: the event is dropped and overflow set. Internal FSM/watchdog still processes the event.
  - Push and pop in the same cycle while full: both happen, no overflow.
  - Push and pop in the same cycle otherwise: level unchanged.
  - Head outputs hold stable while evt_valid & !evt_ready.
  - Pointers wrap modulo DEPTH.
- FSM (evaluated on each accepted event; START=0xAB40, PASS=0xAB51):
  - IDLE, START with stage 0: go to RUN, last_stage = 0.
  - IDLE, START with stage ≠ 0: stage_err = 1, go to RUN, last_stage = stage.
  - IDLE, PASS: stage_err = 1, go to PASS.
  - IDLE, other code: stay in IDLE, log only.
  - RUN, START with stage s: if s < last_stage then stage_err = 1; last_stage = s (equal is allowed).
  - RUN, PASS: go to PASS.
  - RUN, other code: log only, watchdog cleared.
  - RUN, watchdog: increments each cycle, clears on every accepted event. When it reaches TIMEOUT_CYCLES, go to TIMEOUT in that cycle.
  - An event and a timeout in the same cycle: the event wins.
  - PASS and TIMEOUT are terminal until reset. Events are still logged, the watchdog is frozen.
- status/done are registered and update one cycle after the event edge.

Optional Feature:
- Macro CKPT_DEBOUNCE_EN.
- When defined:
  - A new checkbits value must stay constant for DEBOUNCE_CYCLES consecutive cycles before it is accepted.
  - The stagebits sample is taken in the accepting cycle.
  - The timestamp is the acceptance cycle.
  - Detection latency is DEBOUNCE_CYCLES+1.
  - Values shorter than the window are ignored; the window restarts on any change.
- When undefined: the 1-cycle change detect above applies and DEBOUNCE_CYCLES is unused.

Decomposition:
- Package ckpt_pkg holds:
  - START_CODE = 16'hAB40 and PASS_CODE = 16'hAB51.
  - Status enum (IDLE/RUN/PASS/TIMEOUT) and the event record typedef {code, stage, time}.
- Sub-module ckpt_event_fifo: synchronous FIFO with push/pop/level/full/empty, parameterised by DEPTH and the record width.

Test Plan:
- Reset then checkbits=0xAB40, stage=0 → one event {AB40, 00, t}; status=RUN two cycles after the change.
- Stages 0→1→2→9 with AB40, then code 0xAB51 → 5 events in order; status=PASS, done=1, stage_err=0.
- Stage 3 followed by stage 1 under AB40 → stage_err sticks at 1; status stays RUN.
- Start, then no change for 250000 cycles → status=TIMEOUT exactly at watchdog=250000; a change at the same cycle keeps RUN.
- evt_ready=0 with 10 distinct changes, DEPTH=8 → evt_level=8, overflow=1, the first 8 events retained; pop+push while full → no new overflow.
- CKPT_DEBOUNCE_EN: a 2-cycle glitch to 0x1234 → no event; a value held 4 cycles → one event at 5-cycle latency.
